exec_unit_mc: RTL

- Parametrised multi-cycle successor to the single-cycle execute stage.
- Selects operand B (bus or extended 16-bit immediate) and runs either a one-cycle ALU op or an iterative shift-add multiply (MULU/MULS, full 2*WIDTH product).
- Valid/ready handshakes on input and output.
- Sits between register read and writeback in the multi-cycle datapath; drives a stall signal to the controller.

---
 rtl/exec_unit_mc_pkg.sv | 33 +++
 rtl/exec_unit_mc_if.sv | 30 +++
 rtl/exec_unit_mc_seq_mult.sv | 71 +++++++
 rtl/exec_unit_mc.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/exec_unit_mc_pkg.sv
// Op codes, FSM state encoding and op-decode helpers shared by the
// multi-cycle execute unit.
package exec_pkg;

   localparam logic [5:0] OP_SLL  = 6'h00;
   localparam logic [5:0] OP_SRL  = 6'h02;
   localparam logic [5:0] OP_SRA  = 6'h03;
   localparam logic [5:0] OP_MULU = 6'h0e;
   localparam logic [5:0] OP_MULS = 6'h0f;
   localparam logic [5:0] OP_ADD  = 6'h20;
   localparam logic [5:0] OP_SUB  = 6'h22;
   localparam logic [5:0] OP_AND  = 6'h24;
   localparam logic [5:0] OP_OR   = 6'h25;
   localparam logic [5:0] OP_XOR  = 6'h26;
   localparam logic [5:0] OP_NOR  = 6'h27;
   localparam logic [5:0] OP_SLT  = 6'h2a;
   localparam logic [5:0] OP_SLTU = 6'h2b;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   function automatic logic is_mul_op(input logic [5:0] op);
      return (op == OP_MULU) || (op == OP_MULS);
   endfunction

   function automatic logic is_alu_op(input logic [5:0] op);
      case (op)
         OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/exec_unit_mc_if.sv
// Operand/result handshake bundle between register read, the execute
// unit and writeback.
interface exec_unit_mc_if #(parameter int WIDTH = 32);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] busA;
   logic [WIDTH-1:0] busB;
   logic [15:0]      imm16;
   logic             ext_op;
   logic             ALUsrc;
   logic [5:0]       ALU_ctr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_lo;
   logic [WIDTH-1:0] out_hi;
   logic             busy;
   logic             illegal_op;

   modport master (
      output in_valid, busA, busB, imm16, ext_op, ALUsrc, ALU_ctr, out_ready,
      input  in_ready, out_valid, out_lo, out_hi, busy, illegal_op
   );

   modport slave (
      input  in_valid, busA, busB, imm16, ext_op, ALUsrc, ALU_ctr, out_ready,
      output in_ready, out_valid, out_lo, out_hi, busy, illegal_op
   );

endinterface

// File: rtl/exec_unit_mc_seq_mult.sv
// Unsigned iterative shift-add multiplier retiring MUL_BITS multiplier bits
// per cycle into a 2*WIDTH accumulator.
module seq_mult #(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int STEPS = WIDTH / MUL_BITS;
   localparam int CW    = $clog2(STEPS + 1);

   logic               run_q, run_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] partial;

   always_comb begin
      partial = '0;
      for (int i = 0; i < MUL_BITS; i++) begin
         if (mplier_q[i]) partial = partial + (mcand_q << i);
      end
      run_d    = run_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (start) begin
         run_d    = 1'b1;
         cnt_d    = CW'(STEPS);
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
      end else if (run_q) begin
         acc_d    = acc_q + partial;
         mcand_d  = mcand_q << MUL_BITS;
         mplier_d = mplier_q >> MUL_BITS;
         cnt_d    = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) run_d = 1'b0;
      end
   end

   // done flags the final step; product is the accumulator value that step writes
   assign done    = run_q && (cnt_q == CW'(1));
   assign product = acc_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         run_q    <= run_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage: one-cycle ALU ops plus iterative MULU/MULS,
// with valid/ready handshakes on both sides and a busy stall output.
module exec_unit_mc #(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input logic           clk,
   input logic           rst_n,
   exec_unit_mc_if.slave bus
);

   import exec_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               illegal_q, illegal_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;

   logic [WIDTH-1:0]   ext_imm, b_sel, alu_res, a_mag, b_mag;
   logic [SHW-1:0]     shamt;
   logic               is_muls, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod, mul_signed;

   always_comb begin
      ext_imm = bus.ext_op ? WIDTH'($signed(bus.imm16)) : WIDTH'(bus.imm16);
      b_sel   = bus.ALUsrc ? ext_imm : bus.busB;
      shamt   = b_sel[SHW-1:0];
      case (bus.ALU_ctr)
         OP_SLL:  alu_res = bus.busA << shamt;
         OP_SRL:  alu_res = bus.busA >> shamt;
         OP_SRA:  alu_res = $signed(bus.busA) >>> shamt;
         OP_ADD:  alu_res = bus.busA + b_sel;
         OP_SUB:  alu_res = bus.busA - b_sel;
         OP_AND:  alu_res = bus.busA & b_sel;
         OP_OR:   alu_res = bus.busA | b_sel;
         OP_XOR:  alu_res = bus.busA ^ b_sel;
         OP_NOR:  alu_res = ~(bus.busA | b_sel);
         OP_SLT:  alu_res = WIDTH'($signed(bus.busA) < $signed(b_sel));
         OP_SLTU: alu_res = WIDTH'(bus.busA < b_sel);
         default: alu_res = '0;
      endcase
      // MULS multiplies magnitudes; the most-negative value maps to 2^(WIDTH-1)
      is_muls    = (bus.ALU_ctr == OP_MULS);
      a_mag      = (is_muls && bus.busA[WIDTH-1]) ? -bus.busA : bus.busA;
      b_mag      = (is_muls && b_sel[WIDTH-1])    ? -b_sel    : b_sel;
      mul_start  = (state_q == IDLE) && bus.in_valid && is_mul_op(bus.ALU_ctr);
      mul_signed = neg_q ? -mul_prod : mul_prod;
   end

   seq_mult #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) u_mult (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a_mag),
      .b       (b_mag),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      illegal_d   = illegal_q;
      neg_d       = neg_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               in_ready_d = 1'b0;
               if (is_mul_op(bus.ALU_ctr)) begin
                  state_d = MUL;
                  busy_d  = 1'b1;
                  neg_d   = is_muls && (bus.busA[WIDTH-1] ^ b_sel[WIDTH-1]);
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  illegal_d   = !is_alu_op(bus.ALU_ctr);
                  lo_d        = is_alu_op(bus.ALU_ctr) ? alu_res : '0;
                  hi_d        = '0;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               state_d         = DONE;
               busy_d          = 1'b0;
               out_valid_d     = 1'b1;
               illegal_d       = 1'b0;
               {hi_d, lo_d}    = mul_signed;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               illegal_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         illegal_q   <= 1'b0;
         neg_q       <= 1'b0;
         lo_q        <= '0;
         hi_q        <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         illegal_q   <= illegal_d;
         neg_q       <= neg_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.illegal_op = illegal_q;
   assign bus.out_lo     = lo_q;
   assign bus.out_hi     = hi_q;

endmodule
